// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the fetch/branch controller: machine-cycle
// state numbers, the opcodes the sequencer acts on, and the fetch FSM type.
package instr_sequencer_pkg;

  localparam logic [2:0] CYC_A1 = 3'd0;
  localparam logic [2:0] CYC_A2 = 3'd1;
  localparam logic [2:0] CYC_A3 = 3'd2;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_BBL = 4'hC;

  typedef enum logic {
    FETCH1 = 1'b0,
    FETCH2 = 1'b1
  } fsm_state_t;

  // FIM shares opr=2 with SRC; only opa[0]=0 carries a data word.
  function automatic logic is_two_word(input logic [3:0] opr, input logic opa0);
    return (opr == OP_JCN) || (opr == OP_JUN) || (opr == OP_JMS) ||
           (opr == OP_ISZ) || ((opr == OP_FIM) && !opa0);
  endfunction

endpackage

// File: rtl/instr_sequencer_stack.sv
// Circular subroutine return stack. Push writes at sp then advances;
// pop steps back then reads, so dout always shows the entry a pop would take.
// Depth count saturates; a push when full overwrites the oldest entry and
// raises ovf in the same clock. Pops when empty are not flagged.
module return_stack #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              ovf
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STACK_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  w_sp_inc;
  logic [PTR_W-1:0]  w_sp_dec;

  // Modulo-depth pointer neighbours
  always_comb begin
    w_sp_inc = (r_sp == PTR_LAST) ? '0 : r_sp + 1'b1;
    w_sp_dec = (r_sp == '0) ? PTR_LAST : r_sp - 1'b1;
  end

  assign dout = r_mem[w_sp_dec];
  assign ovf  = push && (r_cnt == CNT_FULL);

  // Entry storage, pointer and saturating depth count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_mem[r_sp] <= din;
      r_sp        <= w_sp_inc;
      if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
    end else if (pop) begin
      r_sp <= w_sp_dec;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/branch controller: latches OPR/OPA and the optional second word
// from the ROM nibble stream, decides jumps at X3 of the final word and
// drives the PC load strobe. Owns the return stack (return_stack).
// Optional INSTR_COUNT_EN adds a 16-bit wrapping instr_count output.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cycle,
  input  logic [3:0]        rom_nibble,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              acc_zero,
  input  logic              carry_flag,
  input  logic              test_in,
  input  logic [3:0]        reg_dout,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic [7:0]        imm,
  output logic              second_word,
  output logic              instr_valid,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_new,
  output logic              stack_ovf
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  fsm_state_t        r_state;
  fsm_state_t        w_state_nxt;
  logic [3:0]        r_opr;
  logic [3:0]        r_opa;
  logic [7:0]        r_imm;
  logic [ADDR_W-1:0] r_next_addr;

  logic              w_two_word;
  logic              w_jcn_cond;
  logic              w_push;
  logic              w_pop;
  logic              w_pc_load;
  logic              w_instr_valid;
  logic [ADDR_W-1:0] w_pc_new;
  logic [ADDR_W-1:0] w_long_tgt;
  logic [ADDR_W-1:0] w_page_tgt;
  logic [ADDR_W-1:0] w_stack_dout;
  logic              w_stack_ovf;

  assign w_two_word = is_two_word(r_opr, r_opa[0]);
  assign w_jcn_cond = ((r_opa[2] & acc_zero) | (r_opa[1] & carry_flag) |
                       (r_opa[0] & ~test_in)) ^ r_opa[3];
  assign w_long_tgt = ADDR_W'({r_opa, r_imm});
  // Page comes from the address after the second word, so xFF lands in the next page
  assign w_page_tgt = {r_next_addr[ADDR_W-1:8], r_imm};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH1;
    else     r_state <= w_state_nxt;
  end

  // Next state, branch decision and stack strobes; everything decided at X3
  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_new      = '0;
    w_instr_valid = (cycle == CYC_X1) && ((r_state == FETCH2) || !w_two_word);
    if (cycle == CYC_X3) begin
      unique case (r_state)
        FETCH1: begin
          if (w_two_word) begin
            w_state_nxt = FETCH2;
          end else if (r_opr == OP_BBL) begin
            w_pop     = 1'b1;
            w_pc_load = 1'b1;
            w_pc_new  = w_stack_dout;
          end
        end
        FETCH2: begin
          w_state_nxt = FETCH1;
          case (r_opr)
            OP_JUN: begin
              w_pc_load = 1'b1;
              w_pc_new  = w_long_tgt;
            end
            OP_JMS: begin
              w_push    = 1'b1;
              w_pc_load = 1'b1;
              w_pc_new  = w_long_tgt;
            end
            OP_JCN: begin
              if (w_jcn_cond) begin
                w_pc_load = 1'b1;
                w_pc_new  = w_page_tgt;
              end
            end
            OP_ISZ: begin
              if (reg_dout != 4'hF) begin
                w_pc_load = 1'b1;
                w_pc_new  = w_page_tgt;
              end
            end
            default: ;
          endcase
        end
        default: w_state_nxt = FETCH1;
      endcase
    end
    // Strobes are combinational, so hold them quiet while reset is asserted
    if (rst) begin
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_pc_load     = 1'b0;
      w_pc_new      = '0;
      w_instr_valid = 1'b0;
    end
  end

  // Instruction word latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opr       <= '0;
      r_opa       <= '0;
      r_imm       <= '0;
      r_next_addr <= '0;
    end else if (r_state == FETCH1) begin
      if (cycle == CYC_M1) r_opr <= rom_nibble;
      if (cycle == CYC_M2) r_opa <= rom_nibble;
    end else begin
      if (cycle == CYC_A3) r_next_addr <= pc_addr + 1'b1;
      if (cycle == CYC_M1) r_imm[7:4]  <= rom_nibble;
      if (cycle == CYC_M2) r_imm[3:0]  <= rom_nibble;
    end
  end

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (r_next_addr),
    .dout (w_stack_dout),
    .ovf  (w_stack_ovf)
  );

`ifdef INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // Count completed fetches, wrapping at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_instr_count <= '0;
    else if (w_instr_valid) r_instr_count <= r_instr_count + 1'b1;
  end

  assign instr_count = r_instr_count;
`endif

  assign opr         = r_opr;
  assign opa         = r_opa;
  assign imm         = r_imm;
  assign second_word = (r_state == FETCH2);
  assign instr_valid = w_instr_valid;
  assign pc_load     = w_pc_load;
  assign pc_new      = w_pc_new;
  assign stack_ovf   = w_stack_ovf;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays the ROM and the
// machine-cycle counter; expected branch results are queued per instruction
// and compared when the final word reaches X3.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cycle;
  logic [3:0]  rom_nibble;
  logic [11:0] pc_addr;
  logic        acc_zero, carry_flag, test_in;
  logic [3:0]  reg_dout;
  logic [3:0]  opr, opa;
  logic [7:0]  imm;
  logic        second_word, instr_valid, pc_load, stack_ovf;
  logic [11:0] pc_new;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
  int          n_instr;
`endif

  instr_sequencer #(.ADDR_W(12), .STACK_DEPTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cycle       (cycle),
    .rom_nibble  (rom_nibble),
    .pc_addr     (pc_addr),
    .acc_zero    (acc_zero),
    .carry_flag  (carry_flag),
    .test_in     (test_in),
    .reg_dout    (reg_dout),
    .opr         (opr),
    .opa         (opa),
    .imm         (imm),
    .second_word (second_word),
    .instr_valid (instr_valid),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .stack_ovf   (stack_ovf)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        load;
    logic [11:0] pc;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        sw;
    int          nvalid;
    int          nload;
    logic        load7;
    logic [11:0] pc7;
    logic        ovf7;
    logic [3:0]  opr7;
    logic [3:0]  opa7;
    logic [7:0]  imm7;
  } obs_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Flag values presented at X3; all other cycles see the inverse
  logic       az = 1'b0, cy = 1'b0, ti = 1'b1;
  logic [3:0] rd = 4'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_br(input string tag, input logic load, input logic [11:0] pc,
                           input logic ovf);
    exp_t e;
    e.tag = tag; e.load = load; e.pc = pc; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] c, input logic [3:0] nib, input logic [11:0] addr);
    @(posedge clk);
    #1;
    cycle      = c;
    rom_nibble = nib;
    pc_addr    = addr;
    acc_zero   = (c == 3'd7) ? az : ~az;
    carry_flag = (c == 3'd7) ? cy : ~cy;
    test_in    = (c == 3'd7) ? ti : ~ti;
    reg_dout   = (c == 3'd7) ? rd : ~rd;
    @(negedge clk);
  endtask

  // One 8-state machine cycle fetching the word {hi,lo} from addr
  task automatic mc(input logic [3:0] hi, input logic [3:0] lo, input logic [11:0] addr,
                    output obs_t o);
    logic [2:0] c3;
    o.sw = 1'b0; o.nvalid = 0; o.nload = 0; o.load7 = 1'b0; o.pc7 = '0;
    o.ovf7 = 1'b0; o.opr7 = '0; o.opa7 = '0; o.imm7 = '0;
    for (int c = 0; c < 8; c++) begin
      c3 = 3'(c);
      drive(c3, (c == 3) ? hi : ((c == 4) ? lo : 4'h0), addr);
      if (c == 2) o.sw = second_word;
      if (instr_valid === 1'b1) o.nvalid++;
      if (pc_load === 1'b1) o.nload++;
      if (c == 7) begin
        o.load7 = pc_load; o.pc7 = pc_new; o.ovf7 = stack_ovf;
        o.opr7 = opr; o.opa7 = opa; o.imm7 = imm;
      end
    end
  endtask

  task automatic instr(input string tag, input logic [3:0] o, input logic [3:0] a,
                       input logic [3:0] ih, input logic [3:0] il, input logic [11:0] addr1);
    obs_t w1, w2, fin;
    exp_t e;
    logic two;
    two = (o == 4'h1) || ((o == 4'h2) && !a[0]) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7);
    mc(o, a, addr1, w1);
    chk({tag, ".sw_w1"}, 32'(w1.sw), 0);
    if (two) begin
      chk({tag, ".valid_w1"}, w1.nvalid, 0);
      chk({tag, ".load_w1"}, w1.nload, 0);
      mc(ih, il, addr1 + 12'd1, w2);
      chk({tag, ".sw_w2"}, 32'(w2.sw), 1);
      chk({tag, ".imm"}, 32'(w2.imm7), 32'({ih, il}));
      fin = w2;
    end else begin
      fin = w1;
    end
`ifdef INSTR_COUNT_EN
    n_instr++;
`endif
    chk({tag, ".valid"}, fin.nvalid, 1);
    chk({tag, ".opr"}, 32'(fin.opr7), 32'(o));
    chk({tag, ".opa"}, 32'(fin.opa7), 32'(a));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".load"}, 32'(fin.load7), 32'(e.load));
      chk({e.tag, ".nload"}, fin.nload, e.load ? 1 : 0);
      if (e.load) chk({e.tag, ".pc_new"}, 32'(fin.pc7), 32'(e.pc));
      chk({e.tag, ".ovf"}, 32'(fin.ovf7), 32'(e.ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t w;
    int   nl;
    rst = 1'b1; cycle = 3'd5; rom_nibble = '0; pc_addr = '0;
    acc_zero = 1'b0; carry_flag = 1'b0; test_in = 1'b1; reg_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst.opr", 32'(opr), 0);
    chk("rst.opa", 32'(opa), 0);
    chk("rst.imm", 32'(imm), 0);
    chk("rst.sw", 32'(second_word), 0);
    chk("rst.valid", 32'(instr_valid), 0);
    chk("rst.load", 32'(pc_load), 0);
    chk("rst.pc_new", 32'(pc_new), 0);
    chk("rst.ovf", 32'(stack_ovf), 0);
    rst = 1'b0;
`ifdef INSTR_COUNT_EN
    n_instr = 0;
`endif

    expect_br("jun", 1'b1, 12'h123, 1'b0);
    instr("jun", 4'h4, 4'h1, 4'h2, 4'h3, 12'h000);

    az = 1'b1;
    expect_br("jcn_z1", 1'b1, 12'h155, 1'b0);
    instr("jcn_z1", 4'h1, 4'h4, 4'h5, 4'h5, 12'h0FE);
    az = 1'b0;
    expect_br("jcn_z0", 1'b0, 12'h000, 1'b0);
    instr("jcn_z0", 4'h1, 4'h4, 4'h5, 4'h5, 12'h0FE);

    ti = 1'b0;
    expect_br("jcn_inv_t0", 1'b0, 12'h000, 1'b0);
    instr("jcn_inv_t0", 4'h1, 4'h9, 4'h4, 4'h0, 12'h200);
    ti = 1'b1;
    expect_br("jcn_inv_t1", 1'b1, 12'h240, 1'b0);
    instr("jcn_inv_t1", 4'h1, 4'h9, 4'h4, 4'h0, 12'h200);

    cy = 1'b1;
    expect_br("jcn_c", 1'b1, 12'h2C7, 1'b0);
    instr("jcn_c", 4'h1, 4'h2, 4'hC, 4'h7, 12'h240);
    cy = 1'b0;

    expect_br("jms", 1'b1, 12'h2A0, 1'b0);
    instr("jms", 4'h5, 4'h2, 4'hA, 4'h0, 12'h010);
    expect_br("bbl", 1'b1, 12'h012, 1'b0);
    instr("bbl", 4'hC, 4'h0, 4'h0, 4'h0, 12'h2A0);

    expect_br("jms1", 1'b1, 12'h200, 1'b0);
    instr("jms1", 4'h5, 4'h2, 4'h0, 4'h0, 12'h0FF);
    expect_br("jms2", 1'b1, 12'h300, 1'b0);
    instr("jms2", 4'h5, 4'h3, 4'h0, 4'h0, 12'h1FF);
    expect_br("jms3", 1'b1, 12'h400, 1'b0);
    instr("jms3", 4'h5, 4'h4, 4'h0, 4'h0, 12'h2FF);
    expect_br("jms4_ovf", 1'b1, 12'h500, 1'b1);
    instr("jms4_ovf", 4'h5, 4'h5, 4'h0, 4'h0, 12'h3FF);
    expect_br("bbl1", 1'b1, 12'h401, 1'b0);
    instr("bbl1", 4'hC, 4'h0, 4'h0, 4'h0, 12'h500);
    expect_br("bbl2", 1'b1, 12'h301, 1'b0);
    instr("bbl2", 4'hC, 4'h0, 4'h0, 4'h0, 12'h401);
    expect_br("bbl3", 1'b1, 12'h201, 1'b0);
    instr("bbl3", 4'hC, 4'h0, 4'h0, 4'h0, 12'h301);
    expect_br("bbl4_under", 1'b1, 12'h401, 1'b0);
    instr("bbl4_under", 4'hC, 4'h0, 4'h0, 4'h0, 12'h201);

    rd = 4'hF;
    expect_br("isz_f", 1'b0, 12'h000, 1'b0);
    instr("isz_f", 4'h7, 4'h3, 4'h1, 4'h2, 12'h3FE);
    rd = 4'h3;
    expect_br("isz_3", 1'b1, 12'h412, 1'b0);
    instr("isz_3", 4'h7, 4'h3, 4'h1, 4'h2, 12'h3FE);

    expect_br("fim", 1'b0, 12'h000, 1'b0);
    instr("fim", 4'h2, 4'h4, 4'hA, 4'h5, 12'h412);
    expect_br("src", 1'b0, 12'h000, 1'b0);
    instr("src", 4'h2, 4'h5, 4'h0, 4'h0, 12'h414);
    expect_br("nop", 1'b0, 12'h000, 1'b0);
    instr("nop", 4'h0, 4'h0, 4'h0, 4'h0, 12'h415);

    // Reset during FETCH2 cycle 4 of a JUN
    mc(4'h4, 4'h7, 12'h500, w);
    drive(3'd0, 4'h0, 12'h501);
    drive(3'd1, 4'h0, 12'h501);
    drive(3'd2, 4'h0, 12'h501);
    drive(3'd3, 4'h8, 12'h501);
    chk("rstmid.sw_before", 32'(second_word), 1);
    drive(3'd4, 4'h9, 12'h501);
    rst = 1'b1;
    #1;
    chk("rstmid.opr", 32'(opr), 0);
    chk("rstmid.opa", 32'(opa), 0);
    chk("rstmid.imm", 32'(imm), 0);
    chk("rstmid.sw", 32'(second_word), 0);
    chk("rstmid.load", 32'(pc_load), 0);
    chk("rstmid.pc_new", 32'(pc_new), 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef INSTR_COUNT_EN
    n_instr = 1;
`endif
    nl = 0;
    for (int c = 5; c < 8; c++) begin
      drive(3'(c), 4'h0, 12'h501);
      if (pc_load === 1'b1) nl++;
    end
    chk("rstmid.no_load", nl, 0);

    expect_br("jun_after_rst", 1'b1, 12'h6BC, 1'b0);
    instr("jun_after_rst", 4'h4, 4'h6, 4'hB, 4'hC, 12'h600);

`ifdef INSTR_COUNT_EN
    chk("instr_count", 32'(instr_count), n_instr);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/branch controller for the 4-bit CPU core.
- Latches OPR/OPA from the ROM nibble stream on each 8-state machine cycle and tracks one- versus two-word instructions.
- Evaluates jump conditions and drives pc_load/pc_new into the PC block.
- Owns the 3-level subroutine return stack; decoder/ALU consume its latched opr/opa/imm outputs.

Parameters:
- ADDR_W, 12, program address width.
- STACK_DEPTH, 3, return-stack entries; circular overwrite.

Ports:
- clk  in  1  system clock (toggle clock from clock generator)
- rst  in  1  asynchronous active-high reset
- cycle  in  3  machine-cycle state: 0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
- rom_nibble  in  4  ROM output for current cycle
- pc_addr  in  ADDR_W  address of the word currently being fetched
- acc_zero  in  1  accumulator == 0
- carry_flag  in  1  carry flag
- test_in  in  1  TEST pin
- reg_dout  in  4  index register value, for ISZ
- opr  out  4  latched opcode of the current instruction
- opa  out  4  latched modifier of the current instruction
- imm  out  8  second-word data {OPR2, OPA2}
- second_word  out  1  high while fetching the second word
- instr_valid  out  1  one-clock pulse: instruction fully fetched
- pc_load  out  1  one-clock load strobe to PC
- pc_new  out  ADDR_W  PC load value
- stack_ovf  out  1  one-clock pulse: push overwrote a live entry

Behaviour:
- Reset values:
  - FSM = FETCH1.
  - opr, opa, imm, pc_new = 0.
  - second_word, instr_valid, pc_load, stack_ovf = 0.
  - All stack entries = 0; sp = 0; depth count = 0.
- Reset asserted mid-instruction aborts it and produces no pc_load.
- FSM states: FETCH1, FETCH2. Every transition happens at cycle 7 only.
- FETCH1 latching:
  - cycle 3: opr <= rom_nibble.
  - cycle 4: opa <= rom_nibble.
- Two-word opcodes:
  - JCN: opr=1.
  - FIM: opr=2 with opa[0]=0.
  - JUN: opr=4.
  - JMS: opr=5.
  - ISZ: opr=7.
- FETCH1 exit:
  - Two-word opcode: at cycle 7 go to FETCH2; second_word=1 from the next clock.
  - Otherwise: instr_valid=1 during cycle 5; stay in FETCH1.
- FETCH2 latching:
  - cycle 2: next_addr <= pc_addr+1, mod 2^ADDR_W.
  - cycle 3: imm[7:4] <= rom_nibble.
  - cycle 4: imm[3:0] <= rom_nibble.
  - cycle 5: instr_valid=1.
  - cycle 7: return to FETCH1; second_word=0 from the next clock.
- opr/opa are held unchanged through FETCH2.
- Branch decision is made at cycle 7 of the final word. pc_load=1 for that clock only, with pc_new valid in the same clock.
- JUN: pc_new={opa,imm}.
- JMS:
  - push next_addr.
  - pc_new={opa,imm}.
- JCN:
  - cond = ((opa[2]&acc_zero)|(opa[1]&carry_flag)|(opa[0]&~test_in)) ^ opa[3].
  - Load only if cond; pc_new={next_addr[11:8],imm}.
  - Page rule: a second word at xFF jumps into the next page.
- ISZ:
  - Load if reg_dout != 4'hF; pc_new={next_addr[11:8],imm}.
  - The register increment itself belongs to the datapath.
- BBL (opr=C, single word): pop; pc_new = popped entry; pc_load at cycle 7.
- Other opcodes (including FIM): no pc_load.
- Stack operation:
  - Push writes stack[sp], then sp=(sp+1) mod STACK_DEPTH.
  - Pop does sp=(sp-1) mod STACK_DEPTH, then reads.
  - Depth count saturates at STACK_DEPTH.
- Stack overflow: a push with depth count == STACK_DEPTH overwrites the oldest entry and pulses stack_ovf at cycle 7.
- Stack underflow: a pop with depth 0 returns whatever sits at the wrapped pointer, with no flag.
- Flags are sampled only at cycle 7; changes at other cycles are ignored.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count[15:0], reset 0.
  - Increments on every instr_valid pulse; wraps FFFF->0000.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - cycle-state constants A1..X3;
  - opcode constants OP_JCN, OP_FIM, OP_JUN, OP_JMS, OP_ISZ, OP_BBL;
  - FSM state typedef.
- Sub-module return_stack: push, pop, din, dout, ovf; circular, STACK_DEPTH entries. The JCN condition stays inline.

Test Plan:
- JUN: ROM 0x000=4,1 / 0x001=2,3 -> second_word high for machine cycle 2; cycle 7 pc_load=1, pc_new=0x123.
- JCN on zero:
  - opr=1, opa=4; second word 5,5 at 0x0FF; acc_zero=1 -> pc_new=0x155.
  - Repeat with acc_zero=0 -> no pc_load.
- JCN invert: opa=9 with test_in=0 -> no jump; test_in=1 -> jump.
- JMS/BBL: JMS 0x2A0 from second-word address 0x011 -> pc_new=0x2A0; then BBL -> pc_new=0x012.
- Stack overflow: four nested JMS -> stack_ovf pulse on the 4th; four BBLs return addresses 4,3,2,4.
- Reset: assert rst during FETCH2 cycle 4 -> all outputs 0, FSM FETCH1, no pc_load.
- ISZ: reg_dout=F -> no load; reg_dout=3 -> load.
